// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input stage.
package fft_pkg;

    localparam int N_DEF = 16;
    localparam int W_DEF = 16;
    localparam int LOG2N = $clog2(N_DEF);

    typedef struct packed {
        logic signed [W_DEF-1:0] re;
        logic signed [W_DEF-1:0] im;
    } cplx_t;

    // Reverse the low nbits of idx; used for in-place iterative FFT ordering.
    function automatic int bitrev(input int idx, input int nbits);
        int r;
        r = 0;
        for (int b = 0; b < nbits; b++) begin
            if (idx[b]) r = r | (1 << (nbits - 1 - b));
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Serial sample stream in, parallel frame out, for the FFT frame buffer.
interface fft_frame_buffer_if #(
    parameter int N = 16,
    parameter int W = 16
);
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic signed [W-1:0] frame [N][2];
    logic                frame_valid;
    logic                frame_ready;
    logic                frame_err;

    modport master (
        output in_re, in_im, in_valid, in_last, frame_ready,
        input  in_ready, frame, frame_valid, frame_err
    );

    modport slave (
        input  in_re, in_im, in_valid, in_last, frame_ready,
        output in_ready, frame, frame_valid, frame_err
    );
endinterface

// File: rtl/fft_frame_bank.sv
// N-entry complex register bank: single write port, full parallel read, async clear.
module fft_frame_bank #(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic signed [W-1:0] data_re,
    input  logic signed [W-1:0] data_im,
    output logic signed [W-1:0] q [N][2]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                q[k][0] <= '0;
                q[k][1] <= '0;
            end
        end else if (we) begin
            q[addr][0] <= data_re;
            q[addr][1] <= data_im;
        end
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame collector feeding the butterfly network.
// Define FFT_BITREV_EN to store each frame in bit-reversed order.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_frame_buffer_if.slave bus
);

    localparam int LG = $clog2(N);

    logic [LG-1:0]       wr_cnt;
    logic [LG-1:0]       wr_addr;
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          full;
    logic                frame_err_r;
    logic                accept;
    logic                last_slot;
    logic                complete;
    logic                take;
    logic signed [W-1:0] q0 [N][2];
    logic signed [W-1:0] q1 [N][2];

    assign accept    = bus.in_valid & ~full[wr_bank];
    assign last_slot = (wr_cnt == LG'(N - 1));
    assign complete  = accept & last_slot;
    assign take      = full[rd_bank] & bus.frame_ready;

    assign bus.in_ready    = ~full[wr_bank];
    assign bus.frame_valid = full[rd_bank];
    assign bus.frame_err   = frame_err_r;

`ifdef FFT_BITREV_EN
    assign wr_addr = LG'(bitrev(int'(wr_cnt), LG));
`else
    assign wr_addr = wr_cnt;
`endif

    // Completion and release always target different banks: a bank can only
    // complete while empty and only be released while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt      <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= '0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= accept & (bus.in_last ^ last_slot);
            if (accept) begin
                wr_cnt <= (last_slot | bus.in_last) ? '0 : wr_cnt + LG'(1);
            end
            if (complete) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (take) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    fft_frame_bank #(.N(N), .W(W)) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept & ~wr_bank),
        .addr    (wr_addr),
        .data_re (bus.in_re),
        .data_im (bus.in_im),
        .q       (q0)
    );

    fft_frame_bank #(.N(N), .W(W)) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept & wr_bank),
        .addr    (wr_addr),
        .data_re (bus.in_re),
        .data_im (bus.in_im),
        .q       (q1)
    );

    always_comb begin
        for (int k = 0; k < N; k++) begin
            bus.frame[k][0] = rd_bank ? q1[k][0] : q0[k][0];
            bus.frame[k][1] = rd_bank ? q1[k][1] : q0[k][1];
        end
    end

endmodule
